// File: rtl/sevenseg_pkg.sv
// Shared segment types and glyph constants for the seven-segment scanner.
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active-high internally.
package sevenseg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0    = 7'b0111111;
  localparam seg_t SEG_1    = 7'b0000110;
  localparam seg_t SEG_2    = 7'b1011011;
  localparam seg_t SEG_3    = 7'b1001111;
  localparam seg_t SEG_4    = 7'b1100110;
  localparam seg_t SEG_5    = 7'b1101101;
  localparam seg_t SEG_6    = 7'b1111101;
  localparam seg_t SEG_7    = 7'b0000111;
  localparam seg_t SEG_8    = 7'b1111111;
  localparam seg_t SEG_9    = 7'b1101111;
  localparam seg_t SEG_DASH = 7'b1000000;
  localparam seg_t SEG_OFF  = 7'b0000000;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to seven-segment glyph decoder.
// Non-decimal nibbles (10..15) show a single dash as an error indication.
module bcd_to_7seg
  import sevenseg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output seg_t       o_seg
);

  // Map each nibble value to its glyph; anything above 9 is flagged with a dash
  always_comb begin
    o_seg = SEG_DASH;
    case (i_nibble)
      4'd0: o_seg = SEG_0;
      4'd1: o_seg = SEG_1;
      4'd2: o_seg = SEG_2;
      4'd3: o_seg = SEG_3;
      4'd4: o_seg = SEG_4;
      4'd5: o_seg = SEG_5;
      4'd6: o_seg = SEG_6;
      4'd7: o_seg = SEG_7;
      4'd8: o_seg = SEG_8;
      4'd9: o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/sevenseg_scanner.sv
// Time-multiplexed seven-segment driver. Snapshots the packed BCD word once per
// frame so a value never tears mid-frame, scans one digit per refresh slot with
// a leading anti-ghosting blank window, and optionally blanks leading zeros.
module sevenseg_scanner
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 5,
  parameter int BCD_WIDTH    = 21,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable_i,
  input  logic                  blank_lz_i,
  input  logic [BCD_WIDTH-1:0]  bcd_i,
  output logic [6:0]            seg_o,
  output logic [NUM_DIGITS-1:0] an_o,
  output logic                  frame_o
);

  localparam int   SNAP_W = 4 * NUM_DIGITS;
  localparam int   EXT_W  = (BCD_WIDTH > SNAP_W) ? BCD_WIDTH : SNAP_W;
  localparam int   IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int   PW     = $clog2(REFRESH_DIV);
  localparam logic POL    = (ACTIVE_LOW != 0);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  logic [0:0]            r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [PW-1:0]         r_presc;
  logic [SNAP_W-1:0]     r_snap;
  logic                  r_frame;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_an;

  logic [EXT_W-1:0]      w_bcd_ext;
  logic [SNAP_W-1:0]     w_bcd_trim;
  logic                  w_unused_bcd;
  logic                  w_presc_tc;
  logic                  w_idx_last;
  logic [3:0]            w_nib;
  seg_t                  w_glyph;
  logic [NUM_DIGITS-1:0] w_an_hot;
  logic [NUM_DIGITS-1:0] w_lz_mask;
  logic                  w_zero_above;
  logic                  w_lz_hit;
  logic                  w_vis;
  seg_t                  w_seg_int;
  logic [NUM_DIGITS-1:0] w_an_int;

  // Zero-extend the BCD input, then keep only the digits we display
  assign w_bcd_ext    = EXT_W'(bcd_i);
  assign w_bcd_trim   = w_bcd_ext[SNAP_W-1:0];
  assign w_unused_bcd = ^w_bcd_ext;

  assign w_presc_tc = (r_presc == PW'(REFRESH_DIV - 1));
  assign w_idx_last = (r_idx == IDX_W'(NUM_DIGITS - 1));

  assign w_nib    = 4'(r_snap >> {r_idx, 2'b00});
  assign w_an_hot = NUM_DIGITS'(1) << r_idx;

  bcd_to_7seg u_dec (
    .i_nibble (w_nib),
    .o_seg    (w_glyph)
  );

  // Leading-zero mask: digit k is a leading zero when it and every higher digit are 0
  always_comb begin
    w_lz_mask    = '0;
    w_zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      w_zero_above = w_zero_above & (r_snap[4*k +: 4] == 4'd0);
      w_lz_mask[k] = w_zero_above;
    end
  end

  assign w_lz_hit  = |(w_lz_mask & w_an_hot);
  assign w_vis     = (r_state == ST_SCAN) && (r_presc >= PW'(BLANK_CYCLES));
  assign w_an_int  = w_vis ? w_an_hot : '0;
  assign w_seg_int = (w_vis && !(blank_lz_i && w_lz_hit)) ? w_glyph : SEG_OFF;

  // Scan FSM, prescaler, digit index and per-frame snapshot; disable always wins over a wrap
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_presc <= '0;
      r_snap  <= '0;
      r_frame <= 1'b0;
    end else if (!enable_i) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_presc <= '0;
      r_frame <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_state <= ST_SCAN;
      r_snap  <= w_bcd_trim;
      r_idx   <= '0;
      r_presc <= '0;
      r_frame <= 1'b1;
    end else if (w_presc_tc) begin
      r_presc <= '0;
      if (w_idx_last) begin
        r_idx   <= '0;
        r_snap  <= w_bcd_trim;
        r_frame <= 1'b1;
      end else begin
        r_idx   <= r_idx + IDX_W'(1);
        r_frame <= 1'b0;
      end
    end else begin
      r_presc <= r_presc + PW'(1);
      r_frame <= 1'b0;
    end
  end

  // Pin registers: one cycle behind the counters, polarity applied here
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_seg <= {7{POL}};
      r_an  <= {NUM_DIGITS{POL}};
    end else begin
      r_seg <= w_seg_int ^ {7{POL}};
      r_an  <= w_an_int ^ {NUM_DIGITS{POL}};
    end
  end

  assign seg_o   = r_seg;
  assign an_o    = r_an;
  assign frame_o = r_frame;

endmodule

// File: tb/tb_sevenseg_scanner.sv
// Self-checking bench for sevenseg_scanner with a short refresh slot
// (4 cycles, 1 blank) so whole frames fit in a few dozen cycles.
module tb_sevenseg_scanner;

  typedef logic [4:0][6:0] gl_t;
  typedef struct packed {
    logic [6:0] seg;
    logic [4:0] an;
    logic       fr;
  } exp_t;
  typedef struct {
    string       nm;
    logic [20:0] bcd;
    logic        lz;
    gl_t         g;
  } vec_t;

  localparam logic [6:0] G0 = 7'h3F, G1 = 7'h06, G2 = 7'h5B, G3 = 7'h4F, G4 = 7'h66;
  localparam logic [6:0] G5 = 7'h6D, G8 = 7'h7F, G9 = 7'h6F, GD = 7'h40, GX = 7'h00;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable_i;
  logic        blank_lz_i;
  logic [20:0] bcd_i;
  logic [6:0]  seg_o;
  logic [4:0]  an_o;
  logic        frame_o;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  vec_t vecs[6];

  sevenseg_scanner #(
    .NUM_DIGITS   (5),
    .BCD_WIDTH    (21),
    .REFRESH_DIV  (4),
    .BLANK_CYCLES (1),
    .ACTIVE_LOW   (0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable_i   (enable_i),
    .blank_lz_i (blank_lz_i),
    .bcd_i      (bcd_i),
    .seg_o      (seg_o),
    .an_o       (an_o),
    .frame_o    (frame_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_chk(input string nm, input logic [6:0] s, input logic [4:0] a,
                          input logic f);
    exp_t e;
    sb.push_back('{seg: s, an: a, fr: f});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_tests++;
    if ({seg_o, an_o, frame_o} !== {e.seg, e.an, e.fr}) begin
      n_fail++;
      $display("FAIL %s @%0t: got seg=%b an=%b frame=%b, expected seg=%b an=%b frame=%b",
               nm, $time, seg_o, an_o, frame_o, e.seg, e.an, e.fr);
    end
  endtask

  // Enable from IDLE and check ncyc+1 edges; glyphs ga for frame 0, gb afterwards.
  task automatic run_scan(input string nm, input logic [20:0] ba, input logic [20:0] bb,
                          input int chg, input logic lz, input gl_t ga, input gl_t gb,
                          input int ncyc);
    logic [6:0] s;
    logic [4:0] a;
    int p, slot, pr;
    bcd_i      = ba;
    blank_lz_i = lz;
    enable_i   = 1'b1;
    for (int j = 0; j <= ncyc; j++) begin
      if (j == chg) bcd_i = bb;
      s = GX;
      a = 5'b0;
      if (j > 0) begin
        p    = j - 1;
        slot = (p / 4) % 5;
        pr   = p % 4;
        if (pr >= 1) begin
          a = 5'b00001 << slot;
          s = (p < 20) ? ga[slot] : gb[slot];
        end
      end
      tick_chk(nm, s, a, (j % 20) == 0);
    end
  endtask

  task automatic go_idle();
    enable_i = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    vecs[0] = '{nm: "scan_01234",  bcd: 21'h01234,  lz: 1'b0, g: {G0, G1, G2, G3, G4}};
    vecs[1] = '{nm: "lz_00042",    bcd: 21'h00042,  lz: 1'b1, g: {GX, GX, GX, G4, G2}};
    vecs[2] = '{nm: "lz_zero",     bcd: 21'h00000,  lz: 1'b1, g: {GX, GX, GX, GX, G0}};
    vecs[3] = '{nm: "err_dash",    bcd: 21'h1A0F09, lz: 1'b1, g: {GD, G0, GD, G0, G9}};
    vecs[4] = '{nm: "lz_top_bits", bcd: 21'h100005, lz: 1'b1, g: {GX, GX, GX, GX, G5}};
    vecs[5] = '{nm: "lz_08000",    bcd: 21'h08000,  lz: 1'b1, g: {GX, G8, G0, G0, G0}};

    // Reset held with enable high: everything stays off
    reset_n    = 1'b0;
    enable_i   = 1'b1;
    blank_lz_i = 1'b0;
    bcd_i      = 21'h01234;
    for (int i = 0; i < 3; i++) tick_chk("reset_hold", GX, 5'b0, 1'b0);
    reset_n = 1'b1;
    tick_chk("reset_release_frame", GX, 5'b0, 1'b1);
    go_idle();

    // Table-driven: one frame plus a few cycles of each pattern
    for (int v = 0; v < 6; v++) begin
      run_scan(vecs[v].nm, vecs[v].bcd, vecs[v].bcd, -1, vecs[v].lz,
               vecs[v].g, vecs[v].g, 24);
      go_idle();
    end

    // Snapshot: value changes while digit 2 is on; only the next frame shows it
    run_scan("snapshot", 21'h11111, 21'h22222, 10, 1'b0,
             {G1, G1, G1, G1, G1}, {G2, G2, G2, G2, G2}, 30);
    go_idle();

    // Disable mid-slot: outputs go off one cycle after enable drops
    run_scan("pre_disable", 21'h01234, 21'h01234, -1, 1'b0,
             {G0, G1, G2, G3, G4}, {G0, G1, G2, G3, G4}, 6);
    enable_i = 1'b0;
    tick_chk("disable_lag", G3, 5'b00010, 1'b0);
    tick_chk("disable_off", GX, 5'b0, 1'b0);
    tick_chk("disable_off2", GX, 5'b0, 1'b0);
    run_scan("reenable", 21'h01234, 21'h01234, -1, 1'b0,
             {G0, G1, G2, G3, G4}, {G0, G1, G2, G3, G4}, 8);

    // Reset mid-scan takes priority, then a clean restart
    reset_n = 1'b0;
    tick_chk("reset_mid_scan", GX, 5'b0, 1'b0);
    tick_chk("reset_mid_scan2", GX, 5'b0, 1'b0);
    reset_n = 1'b1;
    run_scan("after_reset", 21'h00042, 21'h00042, -1, 1'b0,
             {G0, G0, G0, G4, G2}, {G0, G0, G0, G4, G2}, 8);
    go_idle();

    // Enable drop exactly at the frame wrap: no frame pulse, no reload
    run_scan("pre_wrap_drop", 21'h01234, 21'h01234, -1, 1'b0,
             {G0, G1, G2, G3, G4}, {G0, G1, G2, G3, G4}, 19);
    enable_i = 1'b0;
    bcd_i    = 21'h00009;
    tick_chk("wrap_drop_lag", G0, 5'b10000, 1'b0);
    tick_chk("wrap_drop_off", GX, 5'b0, 1'b0);
    run_scan("after_wrap_drop", 21'h00009, 21'h00009, -1, 1'b1,
             {GX, GX, GX, GX, G9}, {GX, GX, GX, GX, G9}, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
